// File: rtl/multi_channel_freq_counter.sv
// -----------------------------------------------------------------------------
// multi_channel_freq_counter
//
// Purpose:
//   N-channel gated frequency counter. All channels count rising edges of their
//   asynchronous input over a common gate window. Windows run back-to-back with
//   no dead time. At each window end every channel is snapshotted into a shadow
//   bank. The bank is then drained as a valid/ready stream of per-channel
//   results.
//
// Ports:
//   clk_i          system clock
//   async_rst_i    asynchronous active-low reset; release expected synchronous
//   sig_i          CH_NUM asynchronous measured signals
//   enable_i       run gating; low aborts the current window
//   gate_sel_i     window = GATE_BASE / 10^sel cycles, sampled on (re)arm
//   clr_overrun_i  clears the sticky overrun flag
//   res_data_o     count of the channel currently presented
//   res_ch_o       channel index of res_data_o
//   res_ovf_o      that channel's count saturated
//   res_last_o     presented beat is the final channel
//   res_valid_o    result beat valid
//   res_ready_i    consumer accepts the beat
//   overrun_o      sticky: a snapshot was dropped because the bank was full
//   gate_active_o  a window is currently counting
// -----------------------------------------------------------------------------
module multi_channel_freq_counter #(
    parameter int  CH_NUM    = 4,
    parameter int  CNT_W     = 32,
    parameter int  GATE_BASE = 10_000_000,
    localparam int CH_IDX_W  = (CH_NUM > 1) ? $clog2(CH_NUM) : 1
) (
    input  logic                clk_i,
    input  logic                async_rst_i,
    input  logic [CH_NUM-1:0]   sig_i,
    input  logic                enable_i,
    input  logic [1:0]          gate_sel_i,
    input  logic                clr_overrun_i,
    output logic [CNT_W-1:0]    res_data_o,
    output logic [CH_IDX_W-1:0] res_ch_o,
    output logic                res_ovf_o,
    output logic                res_last_o,
    output logic                res_valid_o,
    input  logic                res_ready_i,
    output logic                overrun_o,
    output logic                gate_active_o
);

    // GATE_BASE-1 is the largest value ever loaded into the gate counter.
    localparam int GATE_W = $clog2(GATE_BASE);

    localparam logic [GATE_W-1:0] GATE_LEN0_M1 = GATE_W'(GATE_BASE - 1);
    localparam logic [GATE_W-1:0] GATE_LEN1_M1 = GATE_W'(GATE_BASE / 10 - 1);
    localparam logic [GATE_W-1:0] GATE_LEN2_M1 = GATE_W'(GATE_BASE / 100 - 1);
    localparam logic [GATE_W-1:0] GATE_LEN3_M1 = GATE_W'(GATE_BASE / 1000 - 1);

    typedef enum logic [1:0] {
        S_IDLE,
        S_ARM,
        S_GATE
    } state_t;

    state_t                r_state;
    state_t                w_state_next;
    logic [GATE_W-1:0]     r_gate_cnt;
    logic [GATE_W-1:0]     w_gate_reload;
    logic                  w_load_gate;
    logic                  w_clr_cnt;
    logic                  w_count_en;
    logic                  w_terminal;

    // Input synchroniser (two flops) plus one edge-detect history flop.
    logic [CH_NUM-1:0]     r_sync1;
    logic [CH_NUM-1:0]     r_sync2;
    logic [CH_NUM-1:0]     r_sync3;
    logic [CH_NUM-1:0]     w_edge;

    logic [CNT_W-1:0]      w_snap_cnt [CH_NUM];
    logic [CH_NUM-1:0]     w_snap_ovf;

    logic [CNT_W-1:0]      r_bank_data [CH_NUM];
    logic [CH_NUM-1:0]     r_bank_ovf;
    logic                  r_full;
    logic [CH_IDX_W-1:0]   r_ptr;
    logic                  r_overrun;
    logic                  w_last;
    logic                  w_fire;
    logic                  w_bank_free;
    logic                  w_bank_load;

    // ---------------------------------------------------------------- FSM
    always_ff @(posedge clk_i or negedge async_rst_i) begin
        if (!async_rst_i) begin
            r_state <= S_IDLE;
        end else begin
            r_state <= w_state_next;
        end
    end

    always_comb begin
        w_state_next = r_state;
        w_load_gate  = 1'b0;
        w_clr_cnt    = 1'b0;
        w_count_en   = 1'b0;
        w_terminal   = 1'b0;
        case (r_state)
            S_IDLE: begin
                w_clr_cnt = 1'b1;
                if (enable_i) begin
                    w_state_next = S_ARM;
                end
            end
            S_ARM: begin
                w_clr_cnt    = 1'b1;
                w_load_gate  = 1'b1;
                w_state_next = enable_i ? S_GATE : S_IDLE;
            end
            S_GATE: begin
                if (!enable_i) begin
                    // Abort: partial counts are discarded, bank untouched.
                    w_clr_cnt    = 1'b1;
                    w_state_next = S_IDLE;
                end else if (r_gate_cnt == '0) begin
                    // Terminal count doubles as an implicit ARM so the next
                    // window starts on the very next cycle.
                    w_terminal  = 1'b1;
                    w_load_gate = 1'b1;
                    w_clr_cnt   = 1'b1;
                end else begin
                    w_count_en = 1'b1;
                end
            end
            default: begin
                w_state_next = S_IDLE;
            end
        endcase
    end

    always_comb begin
        case (gate_sel_i)
            2'd0:    w_gate_reload = GATE_LEN0_M1;
            2'd1:    w_gate_reload = GATE_LEN1_M1;
            2'd2:    w_gate_reload = GATE_LEN2_M1;
            default: w_gate_reload = GATE_LEN3_M1;
        endcase
    end

    always_ff @(posedge clk_i or negedge async_rst_i) begin
        if (!async_rst_i) begin
            r_gate_cnt <= '0;
        end else if (w_load_gate) begin
            r_gate_cnt <= w_gate_reload;
        end else if (w_count_en) begin
            r_gate_cnt <= r_gate_cnt - GATE_W'(1);
        end
    end

    // ------------------------------------------------------- input path
    always_ff @(posedge clk_i or negedge async_rst_i) begin
        if (!async_rst_i) begin
            r_sync1 <= '0;
            r_sync2 <= '0;
            r_sync3 <= '0;
        end else begin
            r_sync1 <= sig_i;
            r_sync2 <= r_sync1;
            r_sync3 <= r_sync2;
        end
    end

    assign w_edge = r_sync2 & ~r_sync3;

    // ------------------------------------------------- per-channel counters
    generate
        for (genvar gi = 0; gi < CH_NUM; gi++) begin : g_ch
            logic [CNT_W-1:0] r_cnt;
            logic             r_ovf;
            logic             w_sat;

            assign w_sat = (r_cnt == '1);
            // The snapshot includes the edge of the terminal cycle itself.
            assign w_snap_cnt[gi] = (w_edge[gi] && !w_sat) ? r_cnt + CNT_W'(1) : r_cnt;
            assign w_snap_ovf[gi] = r_ovf | (w_edge[gi] & w_sat);

            always_ff @(posedge clk_i or negedge async_rst_i) begin
                if (!async_rst_i) begin
                    r_cnt <= '0;
                    r_ovf <= 1'b0;
                end else if (w_clr_cnt) begin
                    r_cnt <= '0;
                    r_ovf <= 1'b0;
                end else if (w_count_en) begin
                    r_cnt <= w_snap_cnt[gi];
                    r_ovf <= w_snap_ovf[gi];
                end
            end
        end
    endgenerate

    // ------------------------------------------------- shadow bank + stream
    assign w_last      = (r_ptr == CH_IDX_W'(CH_NUM - 1));
    assign w_fire      = r_full & res_ready_i;
    // A bank whose last beat is being accepted this cycle counts as empty.
    assign w_bank_free = ~r_full | (w_fire & w_last);
    assign w_bank_load = w_terminal & w_bank_free;

    always_ff @(posedge clk_i or negedge async_rst_i) begin
        if (!async_rst_i) begin
            for (int i = 0; i < CH_NUM; i++) begin
                r_bank_data[i] <= '0;
            end
            r_bank_ovf <= '0;
        end else if (w_bank_load) begin
            for (int i = 0; i < CH_NUM; i++) begin
                r_bank_data[i] <= w_snap_cnt[i];
            end
            r_bank_ovf <= w_snap_ovf;
        end
    end

    always_ff @(posedge clk_i or negedge async_rst_i) begin
        if (!async_rst_i) begin
            r_full <= 1'b0;
            r_ptr  <= '0;
        end else if (w_bank_load) begin
            r_full <= 1'b1;
            r_ptr  <= '0;
        end else if (w_fire) begin
            if (w_last) begin
                r_full <= 1'b0;
                r_ptr  <= '0;
            end else begin
                r_ptr <= r_ptr + CH_IDX_W'(1);
            end
        end
    end

    // Setting wins over clearing when both happen together.
    always_ff @(posedge clk_i or negedge async_rst_i) begin
        if (!async_rst_i) begin
            r_overrun <= 1'b0;
        end else if (w_terminal && !w_bank_free) begin
            r_overrun <= 1'b1;
        end else if (clr_overrun_i) begin
            r_overrun <= 1'b0;
        end
    end

    assign res_valid_o   = r_full;
    assign res_data_o    = r_bank_data[r_ptr];
    assign res_ovf_o     = r_bank_ovf[r_ptr];
    assign res_ch_o      = r_ptr;
    assign res_last_o    = r_full & w_last;
    assign overrun_o     = r_overrun;
    assign gate_active_o = (r_state == S_GATE);

endmodule

// File: tb/tb_multi_channel_freq_counter.sv
// -----------------------------------------------------------------------------
// Bench for multi_channel_freq_counter: a 32-bit instance carries the stream
// and scoreboard checks, a second 8-bit instance exercises saturation.
// -----------------------------------------------------------------------------
module tb_multi_channel_freq_counter;

    logic        clk = 1'b0;
    always #5 clk = ~clk;

    logic        rst_n;
    logic [3:0]  sig;
    logic        enable;
    logic [1:0]  sel;
    logic        clr;
    logic        ready;
    logic [31:0] data;
    logic [1:0]  ch;
    logic        ovf, last, valid, overrun, gact;

    logic        en8, clr8, ready8;
    logic [1:0]  sel8;
    logic [7:0]  data8;
    logic [1:0]  ch8;
    logic        ovf8, last8, valid8, overrun8, gact8;

    multi_channel_freq_counter #(.CH_NUM(4), .CNT_W(32), .GATE_BASE(1000)) u_dut (
        .clk_i(clk), .async_rst_i(rst_n), .sig_i(sig), .enable_i(enable),
        .gate_sel_i(sel), .clr_overrun_i(clr), .res_data_o(data), .res_ch_o(ch),
        .res_ovf_o(ovf), .res_last_o(last), .res_valid_o(valid),
        .res_ready_i(ready), .overrun_o(overrun), .gate_active_o(gact)
    );

    multi_channel_freq_counter #(.CH_NUM(4), .CNT_W(8), .GATE_BASE(1000)) u_dut8 (
        .clk_i(clk), .async_rst_i(rst_n), .sig_i(sig), .enable_i(en8),
        .gate_sel_i(sel8), .clr_overrun_i(clr8), .res_data_o(data8), .res_ch_o(ch8),
        .res_ovf_o(ovf8), .res_last_o(last8), .res_valid_o(valid8),
        .res_ready_i(ready8), .overrun_o(overrun8), .gate_active_o(gact8)
    );

    int checks = 0;
    int errors = 0;
    int period [4];
    int cyc;

    typedef struct {
        int     ch;
        longint data;
        bit     ovf;
        bit     last;
    } beat_t;
    beat_t sb[$];

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
        end
    endtask

    task automatic push_window(input longint d0, input longint d1, input longint d2, input longint d3);
        longint d [4];
        d = '{d0, d1, d2, d3};
        for (int i = 0; i < 4; i++) begin
            sb.push_back('{ch: i, data: d[i], ovf: 1'b0, last: (i == 3)});
        end
    endtask

    task automatic wait_drain(input string tag, input int budget);
        int n = 0;
        while (sb.size() != 0 && n < budget) begin
            @(posedge clk);
            #1;
            n++;
        end
        chk(tag, sb.size(), 0);
    endtask

    // Periodic test signals, duty 50 %, period 0 means constant low.
    initial begin
        cyc = 0;
        sig = '0;
        forever begin
            @(posedge clk);
            #1;
            cyc++;
            for (int c = 0; c < 4; c++) begin
                sig[c] = (period[c] == 0) ? 1'b0 : ((cyc % period[c]) < (period[c] / 2));
            end
        end
    end

    // Stream monitor: pops the scoreboard on every handshake, checks hold
    // stability while stalled.
    initial begin
        bit          stall_prev;
        logic [31:0] held_data;
        logic [1:0]  held_ch;
        beat_t       e;
        stall_prev = 1'b0;
        held_data  = '0;
        held_ch    = '0;
        forever begin
            @(negedge clk);
            if (!rst_n) begin
                stall_prev = 1'b0;
            end else begin
                if (stall_prev) begin
                    chk("hold_valid", valid, 1);
                    chk("hold_data", data, held_data);
                    chk("hold_ch", ch, held_ch);
                end
                if (valid && ready) begin
                    if (sb.size() == 0) begin
                        chk("unexpected_beat_sb_size", sb.size(), 1);
                    end else begin
                        e = sb.pop_front();
                        $display("beat ch=%0d data=%0d ovf=%0d last=%0d (exp ch=%0d data=%0d)",
                                 ch, data, ovf, last, e.ch, e.data);
                        chk("beat_ch", ch, e.ch);
                        chk("beat_data", data, e.data);
                        chk("beat_ovf", ovf, e.ovf);
                        chk("beat_last", last, e.last);
                    end
                end
                stall_prev = valid && !ready;
                held_data  = data;
                held_ch    = ch;
            end
        end
    end

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation did not complete");
        $fatal(1, "watchdog");
    end

    initial begin
        int n;
        int seen;
        logic [7:0] exp8 [4];
        rst_n  = 1'b0;
        enable = 1'b0;
        sel    = 2'd0;
        clr    = 1'b0;
        ready  = 1'b0;
        en8    = 1'b0;
        ready8 = 1'b1;
        sel8   = 2'd0;
        clr8   = 1'b0;
        period = '{10, 4, 0, 2};

        // Reset state
        repeat (3) @(negedge clk);
        chk("rst_valid", valid, 0);
        chk("rst_data", data, 0);
        chk("rst_ch", ch, 0);
        chk("rst_last", last, 0);
        chk("rst_ovf", ovf, 0);
        chk("rst_overrun", overrun, 0);
        chk("rst_gate_active", gact, 0);
        chk("rst_valid8", valid8, 0);
        @(posedge clk);
        #1 rst_n = 1'b1;
        repeat (5) @(posedge clk);
        #1;

        // 1: two full 1000-cycle windows
        ready  = 1'b1;
        sel    = 2'd0;
        enable = 1'b1;
        push_window(100, 250, 0, 500);
        push_window(100, 250, 0, 500);
        wait_drain("t1_drain_timeout", 2600);
        @(posedge clk);
        #1 enable = 1'b0;
        repeat (3) @(negedge clk);
        chk("t1_gate_idle", gact, 0);
        chk("t1_no_overrun", overrun, 0);

        // 4: 8-bit saturation on ch3
        @(posedge clk);
        #1 en8 = 1'b1;
        exp8 = '{8'd100, 8'd250, 8'd0, 8'd255};
        n = 0;
        while (!valid8 && n < 1200) begin
            @(negedge clk);
            n++;
        end
        chk("t4_valid_timeout", valid8, 1);
        for (int i = 0; i < 4; i++) begin
            chk("t4_ch", ch8, i);
            chk("t4_data", data8, exp8[i]);
            chk("t4_ovf", ovf8, (i == 3));
            chk("t4_last", last8, (i == 3));
            @(negedge clk);
        end
        chk("t4_bank_drained", valid8, 0);
        @(posedge clk);
        #1 en8 = 1'b0;

        // 2: 10-cycle window, gate_sel changed mid-window
        period = '{10, 2, 0, 2};
        @(posedge clk);
        #1;
        sel    = 2'd2;
        enable = 1'b1;
        push_window(1, 5, 0, 5);
        push_window(10, 50, 0, 50);
        n = 0;
        while (!gact && n < 10) begin
            @(posedge clk);
            #1;
            n++;
        end
        chk("t2_gate_active", gact, 1);
        repeat (4) @(posedge clk);
        #1 sel = 2'd1;
        wait_drain("t2_drain_timeout", 300);
        @(posedge clk);
        #1 enable = 1'b0;

        // 3: backpressure across three windows, overrun
        period = '{10, 4, 0, 2};
        @(posedge clk);
        #1;
        sel    = 2'd0;
        ready  = 1'b0;
        enable = 1'b1;
        push_window(100, 250, 0, 500);
        n = 0;
        while (!overrun && n < 2300) begin
            @(posedge clk);
            #1;
            n++;
        end
        chk("t3_overrun_set", overrun, 1);
        chk("t3_valid_held", valid, 1);
        chk("t3_bank_data", data, 100);
        chk("t3_bank_ch", ch, 0);
        repeat (1010) @(posedge clk);
        #1 enable = 1'b0;
        chk("t3_overrun_sticky", overrun, 1);
        chk("t3_bank_data_3rd", data, 100);
        @(posedge clk);
        #1 clr = 1'b1;
        @(posedge clk);
        #1 clr = 1'b0;
        chk("t3_overrun_cleared", overrun, 0);
        ready = 1'b1;
        wait_drain("t3_drain_timeout", 20);
        repeat (2) @(negedge clk);
        chk("t3_bank_empty", valid, 0);

        // 5: random backpressure, then last handshake on the terminal cycle
        @(posedge clk);
        #1;
        sel    = 2'd1;
        enable = 1'b1;
        push_window(10, 25, 0, 50);
        push_window(10, 25, 0, 50);
        push_window(10, 25, 0, 50);
        n = 0;
        while (sb.size() != 0 && n < 1000) begin
            @(posedge clk);
            #1;
            ready = 1'($urandom_range(0, 1));
            n++;
        end
        chk("t5_random_drain", sb.size(), 0);
        ready = 1'b0;
        push_window(10, 25, 0, 50);
        push_window(10, 25, 0, 50);
        n = 0;
        while (!valid && n < 300) begin
            @(negedge clk);
            n++;
        end
        chk("t5_bank_valid", valid, 1);
        // Snapshot edge was just before this negedge; the next terminal edge
        // is 100 edges later, so the 4 beats are accepted on edges 97..100.
        repeat (96) @(posedge clk);
        #1 ready = 1'b1;
        repeat (4) @(posedge clk);
        #1 ready = 1'b0;
        chk("t5_coincide_valid", valid, 1);
        chk("t5_coincide_ptr", ch, 0);
        chk("t5_coincide_no_overrun", overrun, 0);
        chk("t5_coincide_queue", sb.size(), 4);
        ready = 1'b1;
        wait_drain("t5_drain_timeout", 20);
        @(posedge clk);
        #1 enable = 1'b0;
        chk("t5_no_overrun", overrun, 0);

        // 6a: async reset mid-gate with bank full
        period = '{0, 2, 0, 2};
        @(posedge clk);
        #1;
        ready  = 1'b0;
        sel    = 2'd2;
        enable = 1'b1;
        n = 0;
        while (!valid && n < 50) begin
            @(negedge clk);
            n++;
        end
        chk("t6_bank_full", valid, 1);
        repeat (3) @(posedge clk);
        #3 rst_n = 1'b0;
        #1;
        chk("t6_rst_valid", valid, 0);
        chk("t6_rst_data", data, 0);
        chk("t6_rst_ch", ch, 0);
        chk("t6_rst_last", last, 0);
        chk("t6_rst_ovf", ovf, 0);
        chk("t6_rst_overrun", overrun, 0);
        chk("t6_rst_gate_active", gact, 0);
        @(posedge clk);
        #1;
        rst_n = 1'b1;
        ready = 1'b1;
        push_window(0, 5, 0, 5);
        n = 0;
        while (!valid && n < 50) begin
            @(posedge clk);
            #1;
            n++;
        end
        chk("t6_first_result_latency", n, 12);
        wait_drain("t6_drain_timeout", 30);
        @(posedge clk);
        #1 enable = 1'b0;

        // 6b: enable dropped mid-gate yields no result
        repeat (2) @(posedge clk);
        #1;
        sel    = 2'd1;
        enable = 1'b1;
        n = 0;
        while (!gact && n < 10) begin
            @(posedge clk);
            #1;
            n++;
        end
        chk("t6_abort_gate_active", gact, 1);
        repeat (50) @(posedge clk);
        #1 enable = 1'b0;
        seen = 0;
        repeat (200) begin
            @(negedge clk);
            if (valid) seen++;
        end
        chk("t6_abort_no_result", seen, 0);
        chk("t6_abort_gate_idle", gact, 0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

// File: doc/multi_channel_freq_counter.md
Name: multi_channel_freq_counter

Overview:
Parametrised N-channel gated frequency counter core, successor to the single-channel counter in the top level. It counts rising edges on CH_NUM asynchronous inputs over a common, run-time selectable gate window. At each window end it snapshots all channels into a shadow bank. The bank is drained as a valid/ready stream of per-channel results toward the UART formatter. Gates run back-to-back with no dead time.

Parameters:
CH_NUM, 4, number of input channels (1..16)
CNT_W, 32, result/count width per channel
GATE_BASE, 10_000_000, gate length in clk_i cycles for gate_sel_i=0 (1 s at 10 MHz); must be a multiple of 1000 and >=1000
CH_IDX_W, derived, max(1, clog2(CH_NUM)); localparam, not overridable

Ports:
clk_i  in  1  system clock
async_rst_i  in  1  asynchronous, active-low reset
sig_i  in  CH_NUM  asynchronous measured signals
enable_i  in  1  run gating; low aborts current window
gate_sel_i  in  2  window = GATE_BASE / 10^sel cycles (1x, /10, /100, /1000)
clr_overrun_i  in  1  clears overrun_o
res_data_o  out  CNT_W  count of current result channel
res_ch_o  out  CH_IDX_W  channel index of res_data_o
res_ovf_o  out  1  this channel's count saturated
res_last_o  out  1  high with final channel (CH_NUM-1)
res_valid_o  out  1  result beat valid
res_ready_i  in  1  consumer accepts beat
overrun_o  out  1  sticky: a snapshot was dropped
gate_active_o  out  1  window currently counting

Behaviour:
- Reset (async_rst_i=0): all outputs 0; FSM=IDLE; counters, shadow bank, pointer cleared. Release is synchronous to clk_i.
- Input path: per-channel 2-FF synchroniser plus 1 edge-detect stage. A rising edge on sig_i increments its counter 3 cycles later.
- FSM IDLE: counters held at 0. enable_i=1 -> ARM.
- FSM ARM (1 cycle):
  - load gate counter with (GATE_BASE/10^gate_sel_i)-1 and clear channel counters.
  - gate_sel_i is sampled here only; later changes take effect at the next ARM/restart.
  - -> GATE.
- FSM GATE:
  - gate_active_o=1; gate counter decrements each cycle.
  - At terminal count (0):
    - snapshot = counter + that cycle's edge, saturated.
    - Counters restart from 0 in the next cycle and gate reloads with freshly sampled gate_sel_i (implicit ARM, no lost cycle).
    - Window is exactly the gate length in cycles.
  - enable_i=0 in any GATE cycle: abort, discard partial counts, -> IDLE; the pending shadow bank is unaffected.
- Counting arithmetic: saturating at 2^CNT_W-1. A per-channel ovf flag is set on saturation and snapshotted with the count.
- Shadow bank and stream:
  - If the bank is empty at terminal count, load all channels, set full, pointer=0.
  - res_valid_o asserts the cycle after the terminal count.
  - res_valid_o = full. The outputs res_data_o, res_ch_o, res_ovf_o and res_last_o come from bank[pointer].
  - On valid&ready: pointer++. When res_last_o is high: full cleared, pointer=0.
  - Outputs are stable while valid&!ready.
- Overrun: terminal count while full -> new snapshot dropped, old bank retained, overrun_o=1. It clears only on clr_overrun_i (set wins if both occur in the same cycle).
- Simultaneous events: terminal count in the same cycle as the last beat handshake counts as empty. The new snapshot is loaded, res_valid_o stays high, and pointer=0 next cycle.
- CH_NUM=1: res_last_o is high on every beat; res_ch_o=0.

Test Plan:
1. CH_NUM=4, GATE_BASE=1000, sel=0, res_ready_i=1; ch0 period 10, ch1 period 4, ch2 const 0, ch3 period 2 -> per window beats ch0..3 = 100, 250, 0, 500; res_last_o only on ch3; no ovf; repeats identically on the 2nd window.
2. sel=2 (10-cycle window), ch3 period 2 -> 5. Switch sel to 1 mid-window -> current window result still 5; next window 50.
3. res_ready_i=0 across 3 windows (ch0 period 10) -> bank holds the first window's 100; overrun_o=1 after 2nd terminal. Pulse clr_overrun_i -> 0. Release ready -> 4 beats of the first snapshot.
4. CNT_W=8, ch3 period 2, GATE_BASE=1000 -> res_data_o=255, res_ovf_o=1; other channels ovf=0.
5. Random res_ready_i backpressure -> beat order 0,1,2,3; data held stable while stalled. Last handshake coinciding with terminal count -> no overrun, new bank streamed.
6. async_rst_i=0 mid-gate with bank full -> all outputs 0 immediately. After release, with enable_i=1, the first result appears only after ARM + one full window. Separately, dropping enable_i mid-gate produces no result for that window.
